maxpool_ctrl: RTL

Frame sequencer for the 2x2 / stride-2 max-pooling datapath (line buffer, stride unit, 4-to-1 max). It accepts a raster pixel stream for one or more feature maps, drives the line-buffer enable and flush, and flags each completed pooling window with its output coordinates. It applies downstream backpressure to the upstream stream and reports start/busy/done for the layer scheduler above it.

---
 rtl/maxpool_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/maxpool_ctrl.sv
// rtl/maxpool_ctrl.sv - 2x2/stride-2 max-pool frame sequencer
// Optional stall counter enabled by MAXPOOL_CTRL_STALL_CNT_EN.
module maxpool_ctrl #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int NUM_MAPS = 4,
    localparam int OR_W    = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1,
    localparam int OC_W    = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1,
    localparam int OM_W    = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            lb_en,
    output logic            lb_flush,
    output logic            pool_valid,
    input  logic            out_ready,
    output logic [OR_W-1:0] out_row,
    output logic [OC_W-1:0] out_col,
    output logic [OM_W-1:0] out_map,
    output logic [31:0]     stall_cnt
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0]   ROW_LAST    = RW'(IMG_H - 1);
    localparam logic [CW-1:0]   COL_LAST    = CW'(IMG_W - 1);
    localparam logic [RW-1:0]   ROW_WIN_MAX = RW'(2 * (IMG_H / 2) - 1);
    localparam logic [CW-1:0]   COL_WIN_MAX = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [OM_W-1:0] MAP_LAST    = OM_W'(NUM_MAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [OM_W-1:0] map;
    logic            accept, start_acc, row_end, col_end, map_end, win_hit;

    // A held, unconsumed window blocks the upstream stream.
    assign in_ready  = (state == S_RUN) && !(pool_valid && !out_ready);
    assign lb_en     = in_valid && in_ready;
    assign accept    = lb_en;
    assign start_acc = (state == S_IDLE) && start;
    assign row_end   = (row == ROW_LAST);
    assign col_end   = (col == COL_LAST);
    assign map_end   = (map == MAP_LAST);
    assign win_hit   = accept && row[0] && col[0] && (row <= ROW_WIN_MAX) && (col <= COL_WIN_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && row_end && col_end && map_end) state_nxt = S_FLUSH;
            S_FLUSH: if (!pool_valid || out_ready) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
            map <= '0;
        end else if (start_acc) begin
            row <= '0;
            col <= '0;
            map <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                if (row_end) begin
                    row <= '0;
                    map <= map_end ? '0 : map + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // A new window overrides consumption of the old one, so no bubble appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lb_flush   <= 1'b0;
            pool_valid <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            out_map    <= '0;
        end else begin
            lb_flush <= accept && row_end && col_end;
            if (win_hit) begin
                pool_valid <= 1'b1;
                out_row    <= OR_W'(row >> 1);
                out_col    <= OC_W'(col >> 1);
                out_map    <= map;
            end else if (out_ready) begin
                pool_valid <= 1'b0;
            end
        end
    end

`ifdef MAXPOOL_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if ((state == S_RUN) && in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule
